seq_mult: RTL and testbench

- Multi-cycle 32x32 unsigned shift-and-add multiplier; 64-bit product.
- Sits directly downstream of the 32-bit ripple-carry adder (ripple). Instantiates exactly one copy, drives its operands every cycle, and consumes its sum and cout.
- Serves as the ALU's multiply unit, with a start/busy/done handshake toward the datapath controller.

---
 rtl/seq_mult.sv | 132 +++++++++++++
 tb/tb_seq_mult.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// Multi-cycle 32x32 unsigned shift-and-add multiplier built around one ripple-carry adder.
// Optional zero-operand shortcut enabled by defining SEQ_MULT_ZERO_BYPASS_EN.

module ripple #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[WIDTH];
endmodule

module seq_mult #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   m_reg, m_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] product_reg, product_next;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    // Add the multiplicand only when the current multiplier bit is set.
    assign addend = lo_reg[0] ? m_reg : '0;

    ripple #(.WIDTH(WIDTH)) u_adder (
        .a    (hi_reg),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            m_reg       <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            m_reg       <= m_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        m_next       = m_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    m_next   = a;
                    hi_next  = '0;
                    lo_next  = b;
                    cnt_next = '0;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
                    if (a == '0 || b == '0) begin
                        state_next   = DONE;
                        product_next = '0;
                    end else begin
                        state_next = RUN;
                    end
`else
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                // The carry-out becomes HI[31], so the 33-bit partial sum never overflows.
                hi_next  = {cout, sum[WIDTH-1:1]};
                lo_next  = {sum[0], lo_reg[WIDTH-1:1]};
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next   = DONE;
                    product_next = {cout, sum, lo_reg[WIDTH-1:1]};
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign product = product_reg;
endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed cases, reset abort, held-start cadence, random pairs.
// Expected products come from plain 64-bit multiplication of the applied operands.

module tb_seq_mult;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int errors = 0;
    int checks = 0;

    seq_mult dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    // One pulsed-start operation; start is toggled randomly and operands scrambled while busy.
    task automatic op(input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [63:0] exp;
        int k;
        int busy_cnt;
        int exp_lat;
        int exp_busy;
        exp = model(x, y);
        exp_lat  = 33;
        exp_busy = 32;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
        if (x == 0 || y == 0) begin
            exp_lat  = 1;
            exp_busy = 0;
        end
`endif
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        busy_cnt = 0;
        while (!done && k < 60) begin
            if (busy) busy_cnt++;
            start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, "_done_latency"}, 64'(k), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({tag, "_product"}, product, exp);
        $display("txn %s a=%08h b=%08h product=%016h latency=%0d", tag, x, y, product, k);
        @(negedge clk);
        check({tag, "_done_pulse_width"}, 64'(done), 64'(0));
        check({tag, "_product_held"}, product, exp);
    endtask

    initial begin
        logic [63:0] exp_q[$];
        logic [31:0] ra;
        logic [31:0] rb;
        int cyc;
        int last;
        int w;
        int done_seen;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_product", product, 64'(0));
        rst = 1'b0;

        op(32'd3, 32'd5, "small");
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones");
        op(32'h8000_0000, 32'd2, "msb_shift");

        // Held start: second accept happens only after the DONE cycle, giving a 34-cycle cadence.
        @(negedge clk);
        a = 32'd7; b = 32'd9; start = 1'b1;
        cyc = 0; last = 0;
        for (int n = 0; n < 2; n++) begin
            w = 0;
            do begin @(negedge clk); cyc++; w++; end while (!done && w < 40);
            check("held_done_seen", 64'(done), 64'(1));
            check("held_product", product, 64'h3F);
            if (n > 0) check("held_spacing", 64'(cyc - last), 64'(34));
            $display("txn held a=7 b=9 product=%016h cycle=%0d", product, cyc);
            last = cyc;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during RUN aborts the operation with no trailing done.
        @(negedge clk);
        a = 32'h1234; b = 32'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_product", product, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'(0));
        $display("txn abort a=00001234 b=00000010 product=%016h", product);
        op(32'h1234, 32'h10, "after_abort");

        op(32'h0, 32'h1234, "zero_a");
        op(32'h5678, 32'h0, "zero_b");

        for (int i = 0; i < 20; i++) op($urandom, $urandom, "rand_pulse");

        // 1000 random pairs with start held high: exact products and fixed 34-cycle spacing.
        @(negedge clk);
        ra = $urandom; rb = $urandom;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
        if (ra == 0) ra = 1;
        if (rb == 0) rb = 1;
`endif
        a = ra; b = rb; start = 1'b1;
        exp_q.push_back(model(ra, rb));
        cyc = 0; last = 0;
        for (int n = 0; n < 1000; n++) begin
            w = 0;
            do begin @(negedge clk); cyc++; w++; end while (!done && w < 40);
            check("rand_done_seen", 64'(done), 64'(1));
            if (n > 0) check("rand_spacing", 64'(cyc - last), 64'(34));
            last = cyc;
            check("rand_product", product, exp_q[0]);
            $display("txn rand %0d a=%08h b=%08h product=%016h", n, ra, rb, product);
            void'(exp_q.pop_front());
            if (n == 999) begin
                start = 1'b0;
            end else begin
                case ($urandom_range(0, 7))
                    0: begin ra = 32'hFFFF_FFFF; rb = $urandom; end
                    1: begin ra = $urandom; rb = 32'h8000_0000; end
                    2: begin ra = 32'd1; rb = $urandom; end
                    default: begin ra = $urandom; rb = $urandom; end
                endcase
`ifdef SEQ_MULT_ZERO_BYPASS_EN
                if (ra == 0) ra = 1;
                if (rb == 0) rb = 1;
`endif
                a = ra; b = rb;
                exp_q.push_back(model(ra, rb));
            end
        end
        repeat (3) @(negedge clk);
        check("final_idle_busy", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
